// File: rtl/spi_slave_with_single_cs_if.sv
// Signal bundle between the SPI slave endpoint and its surroundings:
// board-side SPI pins plus the FPGA-side TX/RX byte handshake.
interface spi_slave_with_single_cs_if #(
  parameter int CNT_W = 2
);
  logic [7:0]       i_TX_Byte;
  logic             i_TX_DV;
  logic             o_TX_Ready;
  logic             o_TX_Underrun;
  logic             o_RX_DV;
  logic [7:0]       o_RX_Byte;
  logic [CNT_W-1:0] o_RX_Count;
  logic             o_CS_Active;
  logic             o_Frame_Done;
  logic             o_Frame_Abort;
  logic             i_SPI_Clk;
  logic             i_SPI_CS_n;
  logic             i_SPI_MOSI;
  logic             o_SPI_MISO;
  logic             o_SPI_MISO_En;

  modport slave (
    input  i_TX_Byte, i_TX_DV, i_SPI_Clk, i_SPI_CS_n, i_SPI_MOSI,
    output o_TX_Ready, o_TX_Underrun, o_RX_DV, o_RX_Byte, o_RX_Count,
           o_CS_Active, o_Frame_Done, o_Frame_Abort, o_SPI_MISO, o_SPI_MISO_En
  );

  modport master (
    output i_TX_Byte, i_TX_DV, i_SPI_Clk, i_SPI_CS_n, i_SPI_MOSI,
    input  o_TX_Ready, o_TX_Underrun, o_RX_DV, o_RX_Byte, o_RX_Count,
           o_CS_Active, o_Frame_Done, o_Frame_Abort, o_SPI_MISO, o_SPI_MISO_En
  );
endinterface

// File: rtl/spi_slave_with_single_cs.sv
// SPI slave endpoint with a single chip select: oversamples SCK/CS_n/MOSI in the
// system clock domain, deserialises MOSI bytes and serialises a held byte on MISO.
module spi_slave_with_single_cs #(
  parameter int         SPI_MODE         = 3,
  parameter int         MAX_BYTES_PER_CS = 2,
  parameter logic [7:0] DEFAULT_TX_BYTE  = 8'hFF
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst_L,
  spi_slave_with_single_cs_if.slave bus
);
  localparam bit CPOL           = SPI_MODE[1];
  localparam bit CPHA           = SPI_MODE[0];
  localparam bit SAMPLE_ON_RISE = (CPOL == CPHA);
  localparam int CNT_W          = $clog2(MAX_BYTES_PER_CS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES_PER_CS);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  logic [1:0] sck_sync_reg, cs_sync_reg, mosi_sync_reg;
  logic       sck_hist_reg, cs_hist_reg, mosi_hist_reg;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sck_sync_reg  <= {2{CPOL}};
      sck_hist_reg  <= CPOL;
      cs_sync_reg   <= 2'b11;
      cs_hist_reg   <= 1'b1;
      mosi_sync_reg <= 2'b00;
      mosi_hist_reg <= 1'b0;
    end else begin
      sck_sync_reg  <= {sck_sync_reg[0], bus.i_SPI_Clk};
      sck_hist_reg  <= sck_sync_reg[1];
      cs_sync_reg   <= {cs_sync_reg[0], bus.i_SPI_CS_n};
      cs_hist_reg   <= cs_sync_reg[1];
      mosi_sync_reg <= {mosi_sync_reg[0], bus.i_SPI_MOSI};
      mosi_hist_reg <= mosi_sync_reg[1];
    end
  end

  logic sck_rise, sck_fall, sample_edge, shift_edge, cs_fall, cs_rise;
  assign sck_rise    = sck_sync_reg[1] & ~sck_hist_reg;
  assign sck_fall    = ~sck_sync_reg[1] & sck_hist_reg;
  assign sample_edge = SAMPLE_ON_RISE ? sck_rise : sck_fall;
  assign shift_edge  = SAMPLE_ON_RISE ? sck_fall : sck_rise;
  assign cs_fall     = ~cs_sync_reg[1] & cs_hist_reg;
  assign cs_rise     = cs_sync_reg[1] & ~cs_hist_reg;

  state_t           state_reg;
  logic [2:0]       bit_cnt_reg;
  logic [6:0]       rx_shift_reg;
  logic [6:0]       tx_shift_reg;
  logic [7:0]       hold_reg;
  logic             hold_full_reg;
  logic             load_pending_reg;
  logic [7:0]       rx_byte_reg;
  logic [CNT_W-1:0] rx_count_reg;
  logic             rx_dv_reg, underrun_reg, frame_done_reg, frame_abort_reg;
  logic             cs_active_reg, miso_reg;

  // A load event starts a new TX byte: at CS assertion for CPHA=0, otherwise on
  // the first shift edge of each byte.
  logic       load_event;
  logic [7:0] load_byte;
  assign load_event = (state_reg == ST_IDLE) ? (cs_fall && !CPHA)
                                             : (shift_edge && load_pending_reg && !cs_rise);
  assign load_byte  = hold_full_reg ? hold_reg : DEFAULT_TX_BYTE;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_reg        <= ST_IDLE;
      bit_cnt_reg      <= '0;
      rx_shift_reg     <= '0;
      tx_shift_reg     <= '0;
      hold_reg         <= '0;
      hold_full_reg    <= 1'b0;
      load_pending_reg <= 1'b0;
      rx_byte_reg      <= '0;
      rx_count_reg     <= '0;
      rx_dv_reg        <= 1'b0;
      underrun_reg     <= 1'b0;
      frame_done_reg   <= 1'b0;
      frame_abort_reg  <= 1'b0;
      cs_active_reg    <= 1'b0;
      miso_reg         <= 1'b0;
    end else begin
      rx_dv_reg       <= 1'b0;
      underrun_reg    <= 1'b0;
      frame_done_reg  <= 1'b0;
      frame_abort_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (cs_fall) begin
            state_reg        <= ST_ACTIVE;
            cs_active_reg    <= 1'b1;
            bit_cnt_reg      <= '0;
            rx_count_reg     <= '0;
            rx_shift_reg     <= '0;
            load_pending_reg <= CPHA;
          end
        end
        ST_ACTIVE: begin
          if (cs_rise) begin
            state_reg        <= ST_IDLE;
            cs_active_reg    <= 1'b0;
            frame_done_reg   <= 1'b1;
            frame_abort_reg  <= (bit_cnt_reg != 3'd0);
            bit_cnt_reg      <= '0;
            tx_shift_reg     <= '0;
            load_pending_reg <= 1'b0;
            miso_reg         <= 1'b0;
          end else begin
            if (sample_edge) begin
              rx_shift_reg <= {rx_shift_reg[5:0], mosi_hist_reg};
              bit_cnt_reg  <= bit_cnt_reg + 3'd1;
              if (bit_cnt_reg == 3'd7) begin
                rx_byte_reg      <= {rx_shift_reg, mosi_hist_reg};
                rx_dv_reg        <= 1'b1;
                load_pending_reg <= 1'b1;
                if (rx_count_reg != MAX_CNT)
                  rx_count_reg <= rx_count_reg + 1'b1;
              end
            end
            if (shift_edge) begin
              if (load_pending_reg) begin
                load_pending_reg <= 1'b0;
              end else begin
                tx_shift_reg <= {tx_shift_reg[5:0], 1'b0};
                miso_reg     <= tx_shift_reg[6];
              end
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase

      // The load reads the old holding byte; a same-cycle write then refills it.
      if (load_event) begin
        tx_shift_reg  <= load_byte[6:0];
        miso_reg      <= load_byte[7];
        hold_full_reg <= 1'b0;
        underrun_reg  <= ~hold_full_reg;
      end
      if (bus.i_TX_DV) begin
        hold_reg      <= bus.i_TX_Byte;
        hold_full_reg <= 1'b1;
      end
    end
  end

  assign bus.o_TX_Ready    = ~hold_full_reg;
  assign bus.o_TX_Underrun = underrun_reg;
  assign bus.o_RX_DV       = rx_dv_reg;
  assign bus.o_RX_Byte     = rx_byte_reg;
  assign bus.o_RX_Count    = rx_count_reg;
  assign bus.o_CS_Active   = cs_active_reg;
  assign bus.o_Frame_Done  = frame_done_reg;
  assign bus.o_Frame_Abort = frame_abort_reg;
  assign bus.o_SPI_MISO    = miso_reg;
  assign bus.o_SPI_MISO_En = cs_active_reg;
endmodule

// File: tb/tb_spi_slave_with_single_cs.sv
// Bench for spi_slave_with_single_cs: a mode-3 and a mode-0 instance driven by a
// bit-banged SPI master, with an RX scoreboard and a table of single-byte frames.
module tb_spi_slave_with_single_cs;
  localparam int HALF = 500;  // SCK half period, 12.5 system clocks

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #20 clk = ~clk;

  spi_slave_with_single_cs_if #(.CNT_W(2)) if3 ();
  spi_slave_with_single_cs_if #(.CNT_W(2)) if0 ();

  spi_slave_with_single_cs #(.SPI_MODE(3), .MAX_BYTES_PER_CS(2), .DEFAULT_TX_BYTE(8'hFF))
    dut3 (.i_Clk(clk), .i_Rst_L(rst_n), .bus(if3.slave));
  spi_slave_with_single_cs #(.SPI_MODE(0), .MAX_BYTES_PER_CS(2), .DEFAULT_TX_BYTE(8'hFF))
    dut0 (.i_Clk(clk), .i_Rst_L(rst_n), .bus(if0.slave));

  typedef struct packed { logic [7:0] b; logic [1:0] c; } rx_exp_t;
  rx_exp_t q3[$];
  rx_exp_t q0[$];

  int total = 0;
  int bad = 0;
  int n_dv[2]    = '{0, 0};
  int n_und[2]   = '{0, 0};
  int n_done[2]  = '{0, 0};
  int n_abort[2] = '{0, 0};
  int n_both[2]  = '{0, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic push(input int d, input logic [7:0] b, input logic [1:0] c);
    rx_exp_t e;
    e.b = b;
    e.c = c;
    if (d == 1) q3.push_back(e);
    else q0.push_back(e);
  endtask

  task automatic rx_seen(input int d, input logic [7:0] b, input logic [1:0] c);
    rx_exp_t e;
    n_dv[d]++;
    if ((d == 1 && q3.size() == 0) || (d == 0 && q0.size() == 0)) begin
      total++;
      bad++;
      $display("FAIL rx_unexpected dut%0d: got byte %02h count %0d, want no RX_DV", d, b, c);
    end else begin
      if (d == 1) e = q3.pop_front();
      else e = q0.pop_front();
      $display("rx dut%0d byte=%02h count=%0d (want %02h/%0d)", d, b, c, e.b, e.c);
      chk($sformatf("rx_byte_dut%0d", d), 32'(b), 32'(e.b));
      chk($sformatf("rx_count_dut%0d", d), 32'(c), 32'(e.c));
    end
  endtask

  always @(negedge clk) begin
    if (if3.o_RX_DV) rx_seen(1, if3.o_RX_Byte, if3.o_RX_Count);
    if (if0.o_RX_DV) rx_seen(0, if0.o_RX_Byte, if0.o_RX_Count);
    if (if3.o_TX_Underrun) n_und[1]++;
    if (if0.o_TX_Underrun) n_und[0]++;
    if (if3.o_Frame_Done) n_done[1]++;
    if (if0.o_Frame_Done) n_done[0]++;
    if (if3.o_Frame_Abort) n_abort[1]++;
    if (if0.o_Frame_Abort) n_abort[0]++;
    if (if3.o_Frame_Done && if3.o_Frame_Abort) n_both[1]++;
    if (if0.o_Frame_Done && if0.o_Frame_Abort) n_both[0]++;
  end

  function automatic int di(input int mode);
    return (mode == 3) ? 1 : 0;
  endfunction

  task automatic set_sck(input int mode, input logic v);
    if (mode == 3) if3.i_SPI_Clk = v; else if0.i_SPI_Clk = v;
  endtask
  task automatic set_cs(input int mode, input logic v);
    if (mode == 3) if3.i_SPI_CS_n = v; else if0.i_SPI_CS_n = v;
  endtask
  task automatic set_mosi(input int mode, input logic v);
    if (mode == 3) if3.i_SPI_MOSI = v; else if0.i_SPI_MOSI = v;
  endtask
  function automatic logic get_miso(input int mode);
    return (mode == 3) ? if3.o_SPI_MISO : if0.o_SPI_MISO;
  endfunction

  task automatic pulse_tx(input int mode, input logic [7:0] b);
    @(negedge clk);
    if (mode == 3) begin if3.i_TX_Byte = b; if3.i_TX_DV = 1'b1; end
    else begin if0.i_TX_Byte = b; if0.i_TX_DV = 1'b1; end
    @(negedge clk);
    if3.i_TX_DV = 1'b0;
    if0.i_TX_DV = 1'b0;
  endtask

  task automatic cs_assert(input int mode);
    set_cs(mode, 1'b0);
    #HALF;
  endtask

  task automatic cs_release(input int mode);
    #HALF;
    set_cs(mode, 1'b1);
    #(4 * HALF);
  endtask

  // Master side: captures MISO just before each sample edge, MSB first.
  task automatic spi_bits(input int mode, input logic [7:0] tx, input int nbits,
                          output logic [7:0] rx);
    logic cpol, cpha;
    cpol = (mode >= 2);
    cpha = (mode == 1) || (mode == 3);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        set_mosi(mode, tx[7-i]);
        #HALF;
        rx = {rx[6:0], get_miso(mode)};
        set_sck(mode, !cpol);
        #HALF;
        set_sck(mode, cpol);
      end else begin
        set_sck(mode, !cpol);
        set_mosi(mode, tx[7-i]);
        #HALF;
        rx = {rx[6:0], get_miso(mode)};
        set_sck(mode, cpol);
        #HALF;
      end
    end
  endtask

  task automatic check_reset(input int mode, input string tag);
    if (mode == 3) begin
      chk({tag, "_tx_ready"}, 32'(if3.o_TX_Ready), 32'd1);
      chk({tag, "_rx_byte"}, 32'(if3.o_RX_Byte), 32'd0);
      chk({tag, "_rx_count"}, 32'(if3.o_RX_Count), 32'd0);
      chk({tag, "_miso"}, 32'(if3.o_SPI_MISO), 32'd0);
      chk({tag, "_miso_en"}, 32'(if3.o_SPI_MISO_En), 32'd0);
      chk({tag, "_pulses"}, 32'({if3.o_RX_DV, if3.o_TX_Underrun, if3.o_Frame_Done,
                                 if3.o_Frame_Abort, if3.o_CS_Active}), 32'd0);
    end else begin
      chk({tag, "_tx_ready"}, 32'(if0.o_TX_Ready), 32'd1);
      chk({tag, "_rx_byte"}, 32'(if0.o_RX_Byte), 32'd0);
      chk({tag, "_miso_en"}, 32'(if0.o_SPI_MISO_En), 32'd0);
    end
  endtask

  typedef struct {
    int         mode;
    bit         preload;
    logic [7:0] tx;
    logic [7:0] mosi;
    logic [7:0] exp_miso;
    int         exp_und;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int d, m, und0, dv0, done0, ab0, both0;
    bit ok;
    logic [7:0] rx;

    // Single-byte frames. Mode 0 always sees one underrun: the closing shift
    // edge of the byte loads a next byte from an empty holding register.
    vecs[0] = '{3, 1'b1, 8'hA5, 8'hC1, 8'hA5, 0};
    vecs[1] = '{3, 1'b1, 8'h00, 8'hFF, 8'h00, 0};
    vecs[2] = '{3, 1'b1, 8'hFF, 8'h00, 8'hFF, 0};
    vecs[3] = '{3, 1'b0, 8'h00, 8'h3C, 8'hFF, 1};
    vecs[4] = '{0, 1'b1, 8'h96, 8'h3E, 8'h96, 1};
    vecs[5] = '{0, 1'b1, 8'h5A, 8'h81, 8'h5A, 1};

    if3.i_TX_Byte = '0; if3.i_TX_DV = 1'b0;
    if3.i_SPI_Clk = 1'b1; if3.i_SPI_CS_n = 1'b1; if3.i_SPI_MOSI = 1'b0;
    if0.i_TX_Byte = '0; if0.i_TX_DV = 1'b0;
    if0.i_SPI_Clk = 1'b0; if0.i_SPI_CS_n = 1'b1; if0.i_SPI_MOSI = 1'b0;

    repeat (4) @(negedge clk);
    check_reset(3, "por3");
    check_reset(0, "por0");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      m = vecs[i].mode;
      d = di(m);
      if (vecs[i].preload) pulse_tx(m, vecs[i].tx);
      und0 = n_und[d]; dv0 = n_dv[d]; done0 = n_done[d]; ab0 = n_abort[d];
      push(d, vecs[i].mosi, 2'd1);
      cs_assert(m);
      spi_bits(m, vecs[i].mosi, 8, rx);
      cs_release(m);
      $display("vec %0d mode=%0d mosi=%02h miso=%02h", i, m, vecs[i].mosi, rx);
      chk($sformatf("v%0d_miso", i), 32'(rx), 32'(vecs[i].exp_miso));
      chk($sformatf("v%0d_underrun", i), n_und[d] - und0, vecs[i].exp_und);
      chk($sformatf("v%0d_rx_dv", i), n_dv[d] - dv0, 1);
      chk($sformatf("v%0d_done", i), n_done[d] - done0, 1);
      chk($sformatf("v%0d_abort", i), n_abort[d] - ab0, 0);
      chk($sformatf("v%0d_pending", i), (d == 1) ? q3.size() : q0.size(), 0);
    end

    // Two-byte frame, second TX byte supplied once the holding register empties
    pulse_tx(3, 8'h5A);
    und0 = n_und[1];
    push(1, 8'hC1, 2'd1);
    push(1, 8'hC2, 2'd2);
    cs_assert(3);
    spi_bits(3, 8'hC1, 8, rx);
    $display("two-byte frame byte0 miso=%02h", rx);
    chk("t2_miso0", 32'(rx), 32'h5A);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (if3.o_TX_Ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("t2_tx_ready", 32'(ok), 32'd1);
    pulse_tx(3, 8'h3C);
    spi_bits(3, 8'hC2, 8, rx);
    $display("two-byte frame byte1 miso=%02h", rx);
    chk("t2_miso1", 32'(rx), 32'h3C);
    cs_release(3);
    chk("t2_underrun", n_und[1] - und0, 0);
    chk("t2_pending", q3.size(), 0);

    // Mode 0 with nothing queued: default byte, underrun at CS assertion
    chk("t3_tx_ready", 32'(if0.o_TX_Ready), 32'd1);
    und0 = n_und[0];
    push(0, 8'h5A, 2'd1);
    cs_assert(0);
    chk("t3_underrun_at_cs", n_und[0] - und0, 1);
    chk("t3_miso_bit7_early", 32'(if0.o_SPI_MISO), 32'd1);
    chk("t3_miso_en", 32'(if0.o_SPI_MISO_En), 32'd1);
    spi_bits(0, 8'h5A, 8, rx);
    $display("mode0 default frame miso=%02h", rx);
    chk("t3_miso", 32'(rx), 32'hFF);
    cs_release(0);
    chk("t3_pending", q0.size(), 0);

    // CS released after 5 bits, then a clean frame
    dv0 = n_dv[1]; done0 = n_done[1]; ab0 = n_abort[1]; both0 = n_both[1];
    cs_assert(3);
    spi_bits(3, 8'hAA, 5, rx);
    cs_release(3);
    $display("aborted frame after 5 bits");
    chk("t4_no_rx_dv", n_dv[1] - dv0, 0);
    chk("t4_done", n_done[1] - done0, 1);
    chk("t4_abort", n_abort[1] - ab0, 1);
    chk("t4_done_with_abort", n_both[1] - both0, 1);
    push(1, 8'h81, 2'd1);
    cs_assert(3);
    spi_bits(3, 8'h81, 8, rx);
    cs_release(3);
    chk("t4_pending", q3.size(), 0);

    // Reset mid-frame with a pending TX byte
    pulse_tx(3, 8'h77);
    cs_assert(3);
    spi_bits(3, 8'hFF, 3, rx);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    $display("reset asserted mid-frame");
    check_reset(3, "t5_rst");
    set_cs(3, 1'b1);
    set_sck(3, 1'b1);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("t5_cs_idle", 32'(if3.o_CS_Active), 32'd0);
    push(1, 8'hF0, 2'd1);
    cs_assert(3);
    spi_bits(3, 8'hF0, 8, rx);
    cs_release(3);
    chk("t5_pending", q3.size(), 0);

    // Three bytes in one frame: the count saturates at 2
    dv0 = n_dv[1];
    push(1, 8'h11, 2'd1);
    push(1, 8'h22, 2'd2);
    push(1, 8'h33, 2'd2);
    cs_assert(3);
    spi_bits(3, 8'h11, 8, rx);
    spi_bits(3, 8'h22, 8, rx);
    spi_bits(3, 8'h33, 8, rx);
    cs_release(3);
    $display("three-byte frame complete");
    chk("t6_rx_dv", n_dv[1] - dv0, 3);
    chk("t6_pending", q3.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
